pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_ctrl_fwd_unit.sv | 22 ++
 rtl/pipe_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding
// selects and the write-data select codes used by the datapath.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MEMWAIT = 2'b01,
        ST_ERR     = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] WDSEL_FROMALU = 2'b00;
    localparam logic [1:0] WDSEL_FROMMEM = 2'b01;
    localparam logic [1:0] WDSEL_FROMPC  = 2'b10;

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] rd, input logic we, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// Operand forwarding select for one EX source register; MEM result wins over WB.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_we_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_we_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (reg_hit(mem_rd_i, mem_we_i, rs_i)) begin
            sel_o = FWD_MEM;
        end else if (reg_hit(wb_rd_i, wb_we_i, rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, load-use stall, redirect
// flush, data-memory wait with timeout, and a saturating stall counter.
//   state      | meaning
//   ST_RUN     | normal issue; load-use / redirect / first memory cycle handled here
//   ST_MEMWAIT | pipeline frozen waiting for dm_ack, timeout counter running
//   ST_ERR     | memory timed out; pipeline held with bubbles until reset
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      ex_rs1,
    input  logic [4:0]      ex_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_RegWrite,
    input  logic [1:0]      ex_WDSel,
    input  logic [4:0]      mem_rd,
    input  logic            mem_RegWrite,
    input  logic [4:0]      wb_rd,
    input  logic            wb_RegWrite,
    input  logic            mem_redirect,
    input  logic            mem_access,
    input  logic            dm_ack,
    output logic            dm_req,
    output logic            pc_en,
    output logic            pc_sel,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            memwb_flush,
    output logic [1:0]      fwdA,
    output logic [1:0]      fwdB,
    output logic [CNTW-1:0] stall_cnt,
    output logic            err
);

    // Down-counter reloaded with TIMEOUT-1 on entry; expiry at zero.
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [CNTW-1:0]   stall_q, stall_d;
    logic              load_use;
    logic              freeze;

    fwd_unit u_fwd_a (
        .rs_i     (ex_rs1),
        .mem_rd_i (mem_rd),
        .mem_we_i (mem_RegWrite),
        .wb_rd_i  (wb_rd),
        .wb_we_i  (wb_RegWrite),
        .sel_o    (fwdA)
    );

    fwd_unit u_fwd_b (
        .rs_i     (ex_rs2),
        .mem_rd_i (mem_rd),
        .mem_we_i (mem_RegWrite),
        .wb_rd_i  (wb_rd),
        .wb_we_i  (wb_RegWrite),
        .sel_o    (fwdB)
    );

    always_comb begin
        load_use = reg_hit(ex_rd, ex_RegWrite && (ex_WDSel == WDSEL_FROMMEM), id_rs1)
                || reg_hit(ex_rd, ex_RegWrite && (ex_WDSel == WDSEL_FROMMEM), id_rs2);
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        freeze      = 1'b0;
        dm_req      = 1'b0;
        pc_en       = 1'b1;
        pc_sel      = 1'b0;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;

        case (state_q)
            ST_RUN: begin
                dm_req = mem_access;
                if (mem_access && !dm_ack) begin
                    freeze  = 1'b1;
                    state_d = ST_MEMWAIT;
                    wait_d  = WW'(TIMEOUT - 1);
                end else if (mem_redirect) begin
                    pc_sel      = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                dm_req = mem_access;
                if (dm_ack) begin
                    state_d = ST_RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_q == '0) begin
                        state_d = ST_ERR;
                    end else begin
                        wait_d = wait_q - 1'b1;
                    end
                end
            end
            default: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_en    = 1'b0;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                memwb_flush = 1'b1;
            end
        endcase

        if (freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end

        // Outputs must already be safe while reset is held, not one edge later.
        if (!rstn) begin
            dm_req      = 1'b0;
            pc_en       = 1'b0;
            pc_sel      = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_en && (stall_q != {CNTW{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
    assign err       = (state_q == ST_ERR);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for the single-cycle decisions plus
// hand-written memory-wait, timeout and reset sequences.
module tb_pipe_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNTW    = 4;

    logic            clk;
    logic            rstn;
    logic [4:0]      id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic            ex_RegWrite, mem_RegWrite, wb_RegWrite;
    logic [1:0]      ex_WDSel;
    logic            mem_redirect, mem_access, dm_ack;
    logic            dm_req, pc_en, pc_sel;
    logic            ifid_en, idex_en, exmem_en, memwb_en;
    logic            ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [1:0]      fwdA, fwdB;
    logic [CNTW-1:0] stall_cnt;
    logic            err;

    pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_RegWrite  (ex_RegWrite),
        .ex_WDSel     (ex_WDSel),
        .mem_rd       (mem_rd),
        .mem_RegWrite (mem_RegWrite),
        .wb_rd        (wb_rd),
        .wb_RegWrite  (wb_RegWrite),
        .mem_redirect (mem_redirect),
        .mem_access   (mem_access),
        .dm_ack       (dm_ack),
        .dm_req       (dm_req),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .memwb_flush  (memwb_flush),
        .fwdA         (fwdA),
        .fwdB         (fwdB),
        .stall_cnt    (stall_cnt),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // en and fl are packed {ifid, idex, exmem, memwb}
    typedef struct {
        string      name;
        logic [4:0] id1, id2, ex1, ex2, exrd;
        logic       exwe;
        logic [1:0] wdsel;
        logic [4:0] memrd;
        logic       memwe;
        logic [4:0] wbrd;
        logic       wbwe;
        logic       redir, acc, ack;
        logic       dmreq, pcen, pcsel;
        logic [3:0] en, fl;
        logic [1:0] fa, fb;
    } vec_t;

    localparam int NV = 18;
    vec_t            tbl [NV];
    int              n_checks;
    int              n_errors;
    logic [CNTW-1:0] exp_stall;
    logic            exp_err;
    vec_t            v;

    function automatic vec_t mk(input string n,
        input logic [4:0] id1, input logic [4:0] id2, input logic [4:0] ex1, input logic [4:0] ex2,
        input logic [4:0] exrd, input logic exwe, input logic [1:0] wdsel,
        input logic [4:0] memrd, input logic memwe, input logic [4:0] wbrd, input logic wbwe,
        input logic redir, input logic acc, input logic ack,
        input logic dmreq, input logic pcen, input logic pcsel,
        input logic [3:0] en, input logic [3:0] fl, input logic [1:0] fa, input logic [1:0] fb);
        vec_t r;
        r.name = n; r.id1 = id1; r.id2 = id2; r.ex1 = ex1; r.ex2 = ex2; r.exrd = exrd;
        r.exwe = exwe; r.wdsel = wdsel; r.memrd = memrd; r.memwe = memwe; r.wbrd = wbrd;
        r.wbwe = wbwe; r.redir = redir; r.acc = acc; r.ack = ack; r.dmreq = dmreq;
        r.pcen = pcen; r.pcsel = pcsel; r.en = en; r.fl = fl; r.fa = fa; r.fb = fb;
        return r;
    endfunction

    function automatic vec_t base(input string n);
        return mk(n, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 2'b00);
    endfunction

    function automatic vec_t frozen(input vec_t x);
        x.dmreq = x.acc; x.pcen = 1'b0; x.pcsel = 1'b0; x.en = 4'b0001; x.fl = 4'b0001;
        return x;
    endfunction

    function automatic vec_t err_out(input vec_t x);
        x.dmreq = 1'b0; x.pcen = 1'b0; x.pcsel = 1'b0; x.en = 4'b0000; x.fl = 4'b1111;
        return x;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        id_rs1 = x.id1; id_rs2 = x.id2; ex_rs1 = x.ex1; ex_rs2 = x.ex2; ex_rd = x.exrd;
        ex_RegWrite = x.exwe; ex_WDSel = x.wdsel; mem_rd = x.memrd; mem_RegWrite = x.memwe;
        wb_rd = x.wbrd; wb_RegWrite = x.wbwe; mem_redirect = x.redir;
        mem_access = x.acc; dm_ack = x.ack;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".dm_req"}, 16'(dm_req), 16'd0);
        chk({tag, ".pc_en"},  16'(pc_en),  16'd0);
        chk({tag, ".en"},     16'({ifid_en, idex_en, exmem_en, memwb_en}), 16'b0000);
        chk({tag, ".fl"},     16'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 16'b1111);
        chk({tag, ".err"},    16'(err), 16'd0);
        chk({tag, ".stall"},  16'(stall_cnt), 16'd0);
    endtask

    // Drive just after a rising edge, check on the falling edge, then clock.
    task automatic run_vec(input vec_t x);
        drive(x);
        @(negedge clk);
        chk({x.name, ".dm_req"}, 16'(dm_req), 16'(x.dmreq));
        chk({x.name, ".pc_en"},  16'(pc_en),  16'(x.pcen));
        chk({x.name, ".pc_sel"}, 16'(pc_sel), 16'(x.pcsel));
        chk({x.name, ".en"},     16'({ifid_en, idex_en, exmem_en, memwb_en}), 16'(x.en));
        chk({x.name, ".fl"},     16'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 16'(x.fl));
        chk({x.name, ".fwdA"},   16'(fwdA), 16'(x.fa));
        chk({x.name, ".fwdB"},   16'(fwdB), 16'(x.fb));
        chk({x.name, ".err"},    16'(err), 16'(exp_err));
        chk({x.name, ".stall"},  16'(stall_cnt), 16'(exp_stall));
        @(posedge clk);
        if (!x.pcen && (exp_stall != {CNTW{1'b1}})) exp_stall = exp_stall + 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        //              name            id1    id2    ex1    ex2    exrd   we    wdsel  memrd  mwe   wbrd   wwe   rdr   acc   ack   dmr   pce   psel  en       fl       fa     fb
        tbl[0]  = mk("idle",          5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 2'b00, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 2'b00);
        tbl[1]  = mk("fwd_mem_pri",   5'd0,  5'd0,  5'd3,  5'd0,  5'd0,  1'b0, 2'b00, 5'd3,  1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 2'b01, 2'b00);
        tbl[2]  = mk("fwd_x0_rs",     5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 2'b00, 5'd3,  1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 2'b00);
        tbl[3]  = mk("fwd_x0_rd",     5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 2'b00, 5'd0,  1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 2'b00);
        tbl[4]  = mk("fwd_wb_both",   5'd0,  5'd0,  5'd7,  5'd7,  5'd0,  1'b0, 2'b00, 5'd7,  1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 2'b10, 2'b10);
        tbl[5]  = mk("fwd_split",     5'd0,  5'd0,  5'd6,  5'd4,  5'd0,  1'b0, 2'b00, 5'd4,  1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 2'b10, 2'b01);
        tbl[6]  = mk("fwd_we_off",    5'd0,  5'd0,  5'd9,  5'd9,  5'd0,  1'b0, 2'b00, 5'd9,  1'b0, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 2'b00);
        tbl[7]  = mk("lu_rs1",        5'd5,  5'd0,  5'd0,  5'd0,  5'd5,  1'b1, 2'b01, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 4'b0100, 2'b00, 2'b00);
        tbl[8]  = mk("lu_rs2",        5'd2,  5'd5,  5'd0,  5'd0,  5'd5,  1'b1, 2'b01, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 4'b0100, 2'b00, 2'b00);
        tbl[9]  = mk("lu_alu",        5'd5,  5'd0,  5'd0,  5'd0,  5'd5,  1'b1, 2'b00, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 2'b00);
        tbl[10] = mk("lu_pc",         5'd5,  5'd0,  5'd0,  5'd0,  5'd5,  1'b1, 2'b10, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 2'b00);
        tbl[11] = mk("lu_nowe",       5'd5,  5'd0,  5'd0,  5'd0,  5'd5,  1'b0, 2'b01, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 2'b00);
        tbl[12] = mk("lu_x0",         5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 2'b01, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 2'b00);
        tbl[13] = mk("redir",         5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 2'b00, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b1110, 2'b00, 2'b00);
        tbl[14] = mk("redir_lu",      5'd5,  5'd0,  5'd0,  5'd0,  5'd5,  1'b1, 2'b01, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b1110, 2'b00, 2'b00);
        tbl[15] = mk("mem_hit",       5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 2'b00, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 2'b00);
        tbl[16] = mk("mem_hit_redir", 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 2'b00, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1110, 2'b00, 2'b00);
        tbl[17] = mk("mem_hit_lu",    5'd5,  5'd0,  5'd0,  5'd0,  5'd5,  1'b1, 2'b01, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0111, 4'b0100, 2'b00, 2'b00);

        n_checks  = 0;
        n_errors  = 0;
        exp_stall = '0;
        exp_err   = 1'b0;

        // Reset held with active inputs: outputs must be forced safe.
        rstn = 1'b0;
        v = base("rst"); v.redir = 1'b1; v.acc = 1'b1;
        drive(v);
        #2;
        chk_reset("reset");
        @(negedge clk);
        drive(base("idle"));
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single load-use bubble, then normal flow.
        run_vec(tbl[7]);
        run_vec(base("after_lu"));
        chk("stall_cnt_after_lu", 16'(stall_cnt), 16'd1);

        for (int i = 0; i < NV; i++) run_vec(tbl[i]);

        // Memory wait: 3 frozen cycles (first one also carries redirect + load-use), release on 4th.
        v = base("mw_c1"); v.acc = 1'b1; v.redir = 1'b1;
        v.id1 = 5'd5; v.exrd = 5'd5; v.exwe = 1'b1; v.wdsel = 2'b01;
        run_vec(frozen(v));
        v = base("mw_c2"); v.acc = 1'b1; run_vec(frozen(v));
        v = base("mw_c3"); v.acc = 1'b1; run_vec(frozen(v));
        v = base("mw_rel"); v.acc = 1'b1; v.ack = 1'b1; v.dmreq = 1'b1;
        run_vec(v);
        v = base("mw_back_run"); v.redir = 1'b1; v.pcsel = 1'b1; v.fl = 4'b1110;
        run_vec(v);

        // Reset in the middle of a memory wait.
        v = base("rw_c1"); v.acc = 1'b1; run_vec(frozen(v));
        v = base("rw_c2"); v.acc = 1'b1; run_vec(frozen(v));
        #2 rstn = 1'b0;
        #1;
        chk_reset("reset_midwait");
        exp_stall = '0;
        drive(base("idle"));
        @(posedge clk);
        #1 rstn = 1'b1;
        v = base("rw_first_run"); v.redir = 1'b1; v.pcsel = 1'b1; v.fl = 4'b1110;
        run_vec(v);

        // Timeout: RUN stall cycle then TIMEOUT MEMWAIT cycles without ack.
        for (int k = 0; k <= TIMEOUT; k++) begin
            v = base($sformatf("to_c%0d", k)); v.acc = 1'b1;
            run_vec(frozen(v));
        end
        exp_err = 1'b1;
        for (int k = 0; k < 12; k++) begin
            v = base($sformatf("err_hold%0d", k));
            v.acc = 1'b1;
            v.ack = (k >= 6);
            v.redir = k[0];
            run_vec(err_out(v));
        end
        chk("stall_cnt_saturated", 16'(stall_cnt), 16'hF);

        #2 rstn = 1'b0;
        #1;
        exp_err   = 1'b0;
        exp_stall = '0;
        chk_reset("reset_from_err");
        drive(base("idle"));
        @(negedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        run_vec(base("post_err_idle"));
        v = base("post_err_redir"); v.redir = 1'b1; v.pcsel = 1'b1; v.fl = 4'b1110;
        run_vec(v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
